// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams a fixed-length message out of word-addressed
// memory, appends 0x80000000, zero fill and the 64-bit bit length, and hands
// complete 512-bit blocks to the compression stage over valid/ready.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         busy,
  output logic         done
);

  localparam int          NBLK      = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam logic [63:0] LEN       = 64'(NUM_OF_WORDS) * 64'd32;
  localparam logic [15:0] NWORDS    = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LAST_BASE = 16'((NBLK - 1) * 16);
  localparam logic [15:0] P_LEN_HI  = 16'(NBLK * 16 - 2);
  localparam logic [15:0] P_LEN_LO  = 16'(NBLK * 16 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, FILL, OFFER, FIN} state_t;

  state_t      state, state_nx;
  logic [15:0] base_addr;   // latched message_addr
  logic [15:0] rd_idx;      // message words issued so far
  logic [4:0]  issued;      // words issued into the current block
  logic [3:0]  wr_slot;     // next block slot to be written
  logic        pend;        // a read issued last cycle returns this cycle
  logic [15:0] blk_base;    // padded-stream index of slot 0
  logic [31:0] words [16];

  logic        issue_en;
  logic        is_last;
  logic [15:0] pad_pos;
  logic [31:0] pad_word;

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign mem_addr  = base_addr + rd_idx;
  assign issue_en  = (state == FETCH) && (issued < 5'd16) && (rd_idx < NWORDS);
  assign is_last   = (blk_base == LAST_BASE);
  assign blk_valid = (state == OFFER);
  assign blk_last  = (state == OFFER) && is_last;
  assign busy      = (state == FETCH) || (state == FILL) || (state == OFFER);
  assign done      = (state == FIN);
  assign pad_pos   = blk_base + {12'd0, wr_slot};

  // Padding word for the slot being filled, chosen by its stream position.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pad_word = 32'h0;
    if (pad_pos == NWORDS)        pad_word = 32'h8000_0000;
    else if (pad_pos == P_LEN_HI) pad_word = LEN[63:32];
    else if (pad_pos == P_LEN_LO) pad_word = LEN[31:0];
  end

  // Flatten the slot array: word 0 in the top 32 bits.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = words[i];
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: if (!issue_en && pend) state_nx = (wr_slot == 4'd15) ? OFFER : FILL;
      FILL:  if (wr_slot == 4'd15) state_nx = OFFER;
      OFFER: if (blk_ready) begin
               if (is_last)              state_nx = FIN;
               else if (rd_idx < NWORDS) state_nx = FETCH;
               else                      state_nx = FILL;
             end
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: address counters, read pipeline tracking and block slot writes.
  // NOTE: the slot array is reset because blk_data has a defined reset value of zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_addr <= '0;
      rd_idx    <= '0;
      issued    <= '0;
      wr_slot   <= '0;
      pend      <= 1'b0;
      blk_base  <= '0;
      for (int i = 0; i < 16; i++) words[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          base_addr <= message_addr;
          rd_idx    <= '0;
          issued    <= '0;
          wr_slot   <= '0;
          pend      <= 1'b0;
          blk_base  <= '0;
          for (int i = 0; i < 16; i++) words[i] <= '0;
        end
        FETCH: begin
          pend <= issue_en;
          if (issue_en) begin
            rd_idx <= rd_idx + 16'd1;
            issued <= issued + 5'd1;
          end
          if (pend) begin
            words[wr_slot] <= mem_read_data;
            wr_slot        <= wr_slot + 4'd1;
          end
        end
        FILL: begin
          words[wr_slot] <= pad_word;
          wr_slot        <= wr_slot + 4'd1;
        end
        OFFER: if (blk_ready && !is_last) begin
          blk_base <= blk_base + 16'd16;
          wr_slot  <= '0;
          issued   <= '0;
          for (int i = 0; i < 16; i++) words[i] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: three instances (20, 13 and 14
// message words) share one memory image; delivered blocks are captured by a
// monitor and compared against a table of hand-computed words.
module tb_sha256_msg_padder;

  localparam int NI = 3;
  localparam int WS [NI]   = '{20, 13, 14};
  localparam int NBLK [NI] = '{2, 1, 2};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start        [NI];
  logic [15:0]  message_addr [NI];
  logic         mem_clk      [NI];
  logic         mem_we       [NI];
  logic [15:0]  mem_addr     [NI];
  logic [31:0]  rdata        [NI];
  logic         blk_valid    [NI];
  logic         blk_ready    [NI];
  logic [511:0] blk_data     [NI];
  logic         blk_last     [NI];
  logic         busy         [NI];
  logic         done         [NI];

  logic [31:0]  mem [65536];

  int           n_vec = 0;
  int           n_bad = 0;

  logic [511:0] cap_data [NI][8];
  logic         cap_last [NI][8];
  int           cap_n    [NI] = '{0, 0, 0};
  int           done_n   [NI] = '{0, 0, 0};
  int           run_base [NI] = '{0, 0, 0};

  typedef struct {
    int          inst;
    int          blk;
    int          word;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha256_msg_padder #(.NUM_OF_WORDS(WS[g])) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start[g]),
      .message_addr (message_addr[g]),
      .mem_clk      (mem_clk[g]),
      .mem_we       (mem_we[g]),
      .mem_addr     (mem_addr[g]),
      .mem_read_data(rdata[g]),
      .blk_valid    (blk_valid[g]),
      .blk_ready    (blk_ready[g]),
      .blk_data     (blk_data[g]),
      .blk_last     (blk_last[g]),
      .busy         (busy[g]),
      .done         (done[g])
    );
  end

  // Synchronous-read memory: data valid one cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) rdata[i] <= mem[mem_addr[i]];
  end

  // Block/done monitor, sampled on the falling edge ahead of the transfer edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset_n && blk_valid[i] && blk_ready[i]) begin
        if (cap_n[i] < 8) begin
          cap_data[i][cap_n[i]] <= blk_data[i];
          cap_last[i][cap_n[i]] <= blk_last[i];
        end
        cap_n[i] <= cap_n[i] + 1;
      end
      if (reset_n && done[i]) done_n[i] <= done_n[i] + 1;
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input int w, input logic [15:0] a, input int p);
    int          nb;
    logic [15:0] ad;
    nb = (w + 2) / 16 + 1;
    if (p < w) begin
      ad = a + 16'(p);
      return 32'hC0DE_0000 | {16'h0, ad};
    end
    if (p == w) return 32'h8000_0000;
    if (p == 16*nb - 1) return 32'(w * 32);
    return 32'h0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_valid%0d", tag, i), blk_valid[i], 0);
      check($sformatf("%s_last%0d", tag, i),  blk_last[i], 0);
      check($sformatf("%s_busy%0d", tag, i),  busy[i], 0);
      check($sformatf("%s_done%0d", tag, i),  done[i], 0);
      check($sformatf("%s_addr%0d", tag, i),  mem_addr[i], 0);
      check($sformatf("%s_data%0d", tag, i),  blk_data[i], 0);
    end
  endtask

  // Run one message on instance i; optionally stall the first block for 10
  // cycles, or re-pulse start with a different address while busy.
  task automatic run(input int i, input logic [15:0] a, input bit stall, input bit restart);
    int           cyc;
    logic [511:0] snap;
    blk_ready[i]    = !stall;
    message_addr[i] = a;
    start[i]        = 1'b1;
    tick;
    start[i]        = 1'b0;
    check($sformatf("busy_after_start%0d", i), busy[i], 1);
    if (stall) begin
      cyc = 0;
      while (!blk_valid[i] && cyc < 100) begin tick; cyc++; end
      check("t4_valid_rise", blk_valid[i], 1);
      snap = blk_data[i];
      for (int k = 0; k < 10; k++) begin
        tick;
        check($sformatf("t4_hold_valid%0d", k), blk_valid[i], 1);
        check($sformatf("t4_hold_data%0d", k), blk_data[i], snap);
      end
      blk_ready[i] = 1'b1;
      tick;
      check("t4_accept_first_ready", blk_valid[i], 0);
    end
    if (restart) begin
      tick;
      tick;
      message_addr[i] = 16'h0200;
      start[i]        = 1'b1;
      tick;
      start[i]        = 1'b0;
      check("t6_still_busy", busy[i], 1);
    end
    cyc = 0;
    while (done[i] !== 1'b1 && cyc < 800) begin tick; cyc++; end
    check($sformatf("done_seen%0d", i), done[i], 1);
    check($sformatf("busy_at_done%0d", i), busy[i], 0);
    tick;
    check($sformatf("done_one_cycle%0d", i), done[i], 0);
  endtask

  initial begin
    int b0;
    int d0;
    logic [31:0] act;

    for (int k = 0; k < 65536; k++) mem[k] = 32'hC0DE_0000 | k;
    for (int n = 0; n < 20; n++) mem[16'h0010 + n] = 32'(n + 1);

    // T1, W=20: block0 = 1..16; block1 = 17..20, 0x80000000, zeros, 0, 0x280
    for (int w = 0; w < 16; w++) tbl.push_back('{0, 0, w, 32'(w + 1)});
    for (int w = 0; w < 4; w++)  tbl.push_back('{0, 1, w, 32'(w + 17)});
    tbl.push_back('{0, 1, 4, 32'h8000_0000});
    for (int w = 5; w < 15; w++) tbl.push_back('{0, 1, w, 32'h0});
    tbl.push_back('{0, 1, 15, 32'h0000_0280});
    // T2, W=13: 1..13, 0x80000000, 0, 0x1A0
    for (int w = 0; w < 13; w++) tbl.push_back('{1, 0, w, 32'(w + 1)});
    tbl.push_back('{1, 0, 13, 32'h8000_0000});
    tbl.push_back('{1, 0, 14, 32'h0});
    tbl.push_back('{1, 0, 15, 32'h0000_01A0});
    // T3, W=14: block0 = 1..14, 0x80000000, 0; block1 = zeros, 0x1C0
    for (int w = 0; w < 14; w++) tbl.push_back('{2, 0, w, 32'(w + 1)});
    tbl.push_back('{2, 0, 14, 32'h8000_0000});
    tbl.push_back('{2, 0, 15, 32'h0});
    for (int w = 0; w < 15; w++) tbl.push_back('{2, 1, w, 32'h0});
    tbl.push_back('{2, 1, 15, 32'h0000_01C0});

    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; message_addr[i] = 16'h0; blk_ready[i] = 1'b1;
    end
    tick;
    tick;
    check_reset_outputs("rst");
    check("mem_we", mem_we[0], 0);
    reset_n = 1'b1;
    tick;

    // T5: reset for one cycle in the middle of block0 fetch
    message_addr[0] = 16'h0010;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    check("t5_in_fetch_addr", mem_addr[0], 16'h0015);
    reset_n = 1'b0;
    tick;
    check_reset_outputs("t5");
    reset_n = 1'b1;
    tick;
    check("t5_no_output", cap_n[0], 0);

    // T1 + T4 on instance 0, then T2 + T6 on instance 1, then T3 on instance 2
    for (int i = 0; i < NI; i++) begin
      run_base[i] = cap_n[i];
      d0 = done_n[i];
      run(i, 16'h0010, i == 0, i == 1);
      for (int k = 0; k < 30; k++) tick;
      check($sformatf("blocks%0d", i), cap_n[i] - run_base[i], NBLK[i]);
      check($sformatf("done_pulses%0d", i), done_n[i] - d0, 1);
      check($sformatf("idle_after%0d", i), busy[i], 0);
      for (int b = 0; b < NBLK[i]; b++)
        check($sformatf("last%0d_b%0d", i, b), cap_last[i][run_base[i] + b], b == NBLK[i] - 1);
    end

    for (int v = 0; v < tbl.size(); v++) begin
      act = cap_data[tbl[v].inst][run_base[tbl[v].inst] + tbl[v].blk][511 - 32*tbl[v].word -: 32];
      check($sformatf("tbl_i%0d_b%0d_w%0d", tbl[v].inst, tbl[v].blk, tbl[v].word), act, tbl[v].exp);
    end

    // Address wrap: W=13 message starting at 0xFFF8 crosses 0xFFFF -> 0x0000
    b0 = cap_n[1];
    run(1, 16'hFFF8, 1'b0, 1'b0);
    tick;
    check("wrap_blocks", cap_n[1] - b0, 1);
    for (int w = 0; w < 16; w++)
      check($sformatf("wrap_w%0d", w), cap_data[1][b0][511 - 32*w -: 32], model_word(13, 16'hFFF8, w));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
